// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER memory arbiter.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned BE_MAX_W = 128;

  // Wide all-ones byte-enable; users truncate to their own byte-enable width.
  localparam logic [BE_MAX_W-1:0] BE_ALL = '1;

endpackage

// File: rtl/otter_rr_pick2.sv
// Two-way round-robin pick: on a conflict the port that did not win last time wins.
module otter_rr_pick2
  import otter_mem_pkg::*;
(
  input  logic  req_i,
  input  logic  req_d,
  input  port_t last,
  output port_t winner,
  output logic  valid
);

  always_comb begin
    winner = PORT_I;
    valid  = req_i | req_d;
    if (req_i && req_d) begin
      winner = (last == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d) begin
      winner = PORT_D;
    end
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (I) and load/store (D),
// one transaction at a time, with round-robin arbitration on conflicts.
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                I_REQ,
  input  logic [ADDR_W-1:0]   I_ADDR,
  output logic                I_GNT,
  output logic                I_DONE,
  output logic [DATA_W-1:0]   I_RDATA,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  input  logic [DATA_W/8-1:0] D_BE,
  output logic                D_GNT,
  output logic                D_DONE,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                MEM_EN,
  output logic                MEM_WE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_WDATA,
  output logic [DATA_W/8-1:0] MEM_BE,
  input  logic [DATA_W-1:0]   MEM_RDATA
);

  localparam int unsigned     BE_W     = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  port_t             owner_q, owner_d;
  port_t             last_q, last_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  port_t             win_c;
  logic              win_valid_c;
  logic              i_gnt_c, d_gnt_c, mem_en_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [BE_W-1:0]   mem_be_c;

  otter_rr_pick2 u_pick (
    .req_i  (I_REQ),
    .req_d  (D_REQ),
    .last   (last_q),
    .winner (win_c),
    .valid  (win_valid_c)
  );

  // Next-state and memory-side mux; DONE doubles as an IDLE cycle for back-to-back grants.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_gnt_c     = 1'b0;
    d_gnt_c     = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_be_c    = '0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (win_valid_c) begin
          state_d  = WAIT;
          owner_d  = win_c;
          last_d   = win_c;
          we_d     = (win_c == PORT_D) && D_WE;
          cnt_d    = CNT_INIT;
          mem_en_c = 1'b1;
          if (win_c == PORT_D) begin
            d_gnt_c     = 1'b1;
            mem_we_c    = D_WE;
            mem_addr_c  = D_ADDR;
            mem_wdata_c = D_WDATA;
            mem_be_c    = D_BE;
          end else begin
            i_gnt_c    = 1'b1;
            mem_addr_c = I_ADDR;
            mem_be_c   = BE_W'(BE_ALL);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (owner_q == PORT_I) begin
            i_rdata_d = MEM_RDATA;
          end else if (!we_q) begin
            d_rdata_d = MEM_RDATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= PORT_I;
      last_q    <= PORT_I;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Grant-side outputs are forced quiet while reset is held, even with requests pending.
  assign I_GNT     = RST_N & i_gnt_c;
  assign D_GNT     = RST_N & d_gnt_c;
  assign MEM_EN    = RST_N & mem_en_c;
  assign MEM_WE    = RST_N & mem_we_c;
  assign MEM_ADDR  = RST_N ? mem_addr_c  : '0;
  assign MEM_WDATA = RST_N ? mem_wdata_c : '0;
  assign MEM_BE    = RST_N ? mem_be_c    : '0;

  assign I_DONE  = (state_q == DONE) && (owner_q == PORT_I);
  assign D_DONE  = (state_q == DONE) && (owner_q == PORT_D);
  assign I_RDATA = i_rdata_q;
  assign D_RDATA = d_rdata_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: vector table, directed corner cases,
// a MEM_LAT=1 instance, and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_otter_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        l1_i_req, l1_i_gnt, l1_i_done, l1_d_gnt, l1_d_done, l1_mem_en, l1_mem_we;
  logic [31:0] l1_i_addr, l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [3:0]  l1_mem_be;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem  [logic [31:0]];
  logic [31:0] due1 [int];
  logic [31:0] due2 [int];

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        e_ig;
    logic        e_dg;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vt [6];

  always #5 clk = ~clk;

  otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .CLK(clk), .RST_N(rst_n),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt), .I_DONE(i_done), .I_RDATA(i_rdata),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata), .D_BE(d_be),
    .D_GNT(d_gnt), .D_DONE(d_done), .D_RDATA(d_rdata),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_BE(mem_be), .MEM_RDATA(mem_rdata)
  );

  otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .CLK(clk), .RST_N(rst_n),
    .I_REQ(l1_i_req), .I_ADDR(l1_i_addr), .I_GNT(l1_i_gnt), .I_DONE(l1_i_done),
    .I_RDATA(l1_i_rdata),
    .D_REQ(1'b0), .D_WE(1'b0), .D_ADDR(32'h0), .D_WDATA(32'h0), .D_BE(4'h0),
    .D_GNT(l1_d_gnt), .D_DONE(l1_d_done), .D_RDATA(l1_d_rdata),
    .MEM_EN(l1_mem_en), .MEM_WE(l1_mem_we), .MEM_ADDR(l1_mem_addr),
    .MEM_WDATA(l1_mem_wdata), .MEM_BE(l1_mem_be), .MEM_RDATA(l1_mem_rdata)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  // Start of a cycle: memory read data for this cycle appears, then stimulus may change.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata    = due1.exists(cyc) ? due1[cyc] : $urandom();
    l1_mem_rdata = due2.exists(cyc) ? due2[cyc] : $urandom();
  endtask

  // Mid-cycle: memory samples the access strobe and schedules read data LAT cycles out.
  task automatic mid();
    logic [31:0] w;
    @(negedge clk);
    if (mem_en) begin
      if (mem_we) begin
        w = mem_rd(mem_addr);
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr] = w;
      end else begin
        due1[cyc + LAT] = mem_rd(mem_addr);
      end
    end
    if (l1_mem_en) due2[cyc + 1] = l1_mem_addr ^ 32'hA5A50000;
  endtask

  task automatic clr_in();
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    l1_i_req = 1'b0; l1_i_addr = 32'h0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    due1.delete();
    due2.delete();
  endtask

  task automatic chk_quiet(input string name);
    chk1({name, "_ignt"}, i_gnt, 1'b0);
    chk1({name, "_dgnt"}, d_gnt, 1'b0);
    chk1({name, "_idone"}, i_done, 1'b0);
    chk1({name, "_ddone"}, d_done, 1'b0);
    chk1({name, "_men"}, mem_en, 1'b0);
    chk1({name, "_mwe"}, mem_we, 1'b0);
    chk32({name, "_maddr"}, mem_addr, 32'h0);
    chk32({name, "_mwdata"}, mem_wdata, 32'h0);
    chk32({name, "_mbe"}, 32'(mem_be), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int          free_at, done_at;
    logic        last_m, pend, pend_port, pend_wr, win, eg_i, eg_d, prev_gi, prev_gd;
    logic [31:0] pend_data, exp_ir, exp_dr, pre;

    vt[0] = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h40,   32'h1234,     4'hF,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0};
    vt[1] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h40,   32'h1234,     4'h3,
              1'b1, 1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        4'hF};
    vt[2] = '{1'b0, 32'h100, 1'b1, 1'b0, 32'h40,   32'h1234,     4'h5,
              1'b0, 1'b1, 1'b1, 1'b0, 32'h40,   32'h1234,     4'h5};
    vt[3] = '{1'b0, 32'h100, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3,
              1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3};
    vt[4] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h48,   32'h0,        4'hF,
              1'b0, 1'b1, 1'b1, 1'b0, 32'h48,   32'h0,        4'hF};
    vt[5] = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h4C,   32'hCAFE0000, 4'hC,
              1'b0, 1'b1, 1'b1, 1'b1, 32'h4C,   32'hCAFE0000, 4'hC};

    // Reset state, with both requests high to confirm grants stay quiet under reset.
    clr_in();
    rst_n = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h40;
    next_cycle();
    mid();
    chk_quiet("rst");
    chk32("rst_irdata", i_rdata, 32'h0);
    chk32("rst_drdata", d_rdata, 32'h0);
    chk1("rst_l1_ignt", l1_i_gnt, 1'b0);

    // Vector table: first-cycle grant decision and memory mux from a fresh reset.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      next_cycle();
      i_req = vt[v].i_req; i_addr = vt[v].i_addr;
      d_req = vt[v].d_req; d_we = vt[v].d_we; d_addr = vt[v].d_addr;
      d_wdata = vt[v].d_wdata; d_be = vt[v].d_be;
      mid();
      chk1($sformatf("vec%0d_ignt", v), i_gnt, vt[v].e_ig);
      chk1($sformatf("vec%0d_dgnt", v), d_gnt, vt[v].e_dg);
      chk1($sformatf("vec%0d_men", v), mem_en, vt[v].e_en);
      chk1($sformatf("vec%0d_mwe", v), mem_we, vt[v].e_we);
      chk32($sformatf("vec%0d_maddr", v), mem_addr, vt[v].e_addr);
      chk32($sformatf("vec%0d_mwdata", v), mem_wdata, vt[v].e_wdata);
      chk32($sformatf("vec%0d_mbe", v), 32'(mem_be), 32'(vt[v].e_be));
    end

    // Single fetch: grant in cycle 0, DONE with data in cycle 3.
    do_reset();
    mem[32'h100] = 32'h00000013;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      i_req = (c == 0); i_addr = 32'h100;
      mid();
      chk1("fetch_ignt", i_gnt, c == 0);
      chk1("fetch_men", mem_en, c == 0);
      chk32("fetch_maddr", mem_addr, (c == 0) ? 32'h100 : 32'h0);
      chk1("fetch_idone", i_done, c == 3);
      chk1("fetch_ddone", d_done, 1'b0);
      if (c == 0) chk32("fetch_mbe", 32'(mem_be), 32'hF);
      if (c >= 3) chk32("fetch_irdata", i_rdata, 32'h00000013);
    end

    // MEM_LAT=1 instance: grant in cycle 0, DONE in cycle 2.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      l1_i_req = (c == 0); l1_i_addr = 32'h80;
      mid();
      chk1("lat1_ignt", l1_i_gnt, c == 0);
      chk1("lat1_idone", l1_i_done, c == 2);
      chk1("lat1_dgnt", l1_d_gnt, 1'b0);
      chk1("lat1_ddone", l1_d_done, 1'b0);
      chk32("lat1_drdata", l1_d_rdata, 32'h0);
      chk32("lat1_irdata", l1_i_rdata, (c >= 2) ? (32'h80 ^ 32'hA5A50000) : 32'h0);
      if (c == 0) begin
        chk1("lat1_mwe", l1_mem_we, 1'b0);
        chk32("lat1_mbe", 32'(l1_mem_be), 32'hF);
        chk32("lat1_mwdata", l1_mem_wdata, 32'h0);
      end
    end

    // Conflict fairness: both held high, grants alternate D, I, D, I every 3 cycles.
    do_reset();
    mem[32'h200] = 32'h11110200;
    mem[32'h300] = 32'h33330300;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0; d_be = 4'hF;
      mid();
      chk1("conf_dgnt", d_gnt, (c % 6) == 0);
      chk1("conf_ignt", i_gnt, (c % 6) == 3);
      chk1("conf_ddone", d_done, (c % 6) == 3);
      chk1("conf_idone", i_done, ((c % 6) == 0) && (c > 0));
      if (c >= 3) chk32("conf_drdata", d_rdata, 32'h33330300);
      if (c >= 6) chk32("conf_irdata", i_rdata, 32'h11110200);
    end

    // Write: D_RDATA keeps the earlier load value; memory gets only the enabled bytes.
    do_reset();
    mem[32'h44] = 32'h44444444;
    pre = mem_rd(32'h2000);
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      clr_in();
      if (c == 0) begin d_req = 1'b1; d_addr = 32'h44; d_be = 4'hF; end
      if (c == 4) begin
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
      end
      mid();
      chk1("wr_dgnt", d_gnt, (c == 0) || (c == 4));
      chk1("wr_ddone", d_done, (c == 3) || (c == 7));
      if (c == 4) begin
        chk1("wr_mwe", mem_we, 1'b1);
        chk32("wr_mbe", 32'(mem_be), 32'h3);
        chk32("wr_maddr", mem_addr, 32'h2000);
        chk32("wr_mwdata", mem_wdata, 32'hDEADBEEF);
      end
      if (c >= 3) chk32("wr_drdata", d_rdata, 32'h44444444);
    end
    chk32("wr_memword", mem_rd(32'h2000), {pre[31:16], 16'hBEEF});

    // Back-to-back D reads: second grant lands in the first DONE cycle.
    do_reset();
    mem[32'h10] = 32'hAAAA0010;
    mem[32'h14] = 32'hBBBB0014;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      d_req = (c < 4); d_we = 1'b0; d_be = 4'hF;
      d_addr = (c == 0) ? 32'h10 : 32'h14;
      mid();
      chk1("b2b_dgnt", d_gnt, (c == 0) || (c == 3));
      chk1("b2b_ddone", d_done, (c == 3) || (c == 6));
      if (c == 3) chk32("b2b_maddr", mem_addr, 32'h14);
      if (c >= 3 && c < 6) chk32("b2b_drdata1", d_rdata, 32'hAAAA0010);
      if (c >= 6) chk32("b2b_drdata2", d_rdata, 32'hBBBB0014);
    end

    // Reset in the WAIT cycle of a second fetch: outputs clear at once, access is dropped.
    do_reset();
    mem[32'h100] = 32'h00000013;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      i_req = (c == 0) || (c == 4);
      i_addr = (c >= 4) ? 32'h104 : 32'h100;
      if (c == 5) begin
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h48;
        rst_n = 1'b0;
        #1;
        chk_quiet("rstmid");
        chk32("rstmid_irdata", i_rdata, 32'h0);
      end
      mid();
      if (c < 5) chk1("rstmid_ignt", i_gnt, (c == 0) || (c == 4));
      if (c == 3) chk32("rstmid_irdata_pre", i_rdata, 32'h00000013);
    end
    next_cycle();
    next_cycle();
    clr_in();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      mid();
      chk1("rstmid_noidone", i_done, 1'b0);
      chk1("rstmid_noen", mem_en, 1'b0);
    end
    next_cycle();
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h48;
    mid();
    chk1("rstmid_dwins", d_gnt, 1'b1);
    chk1("rstmid_ilose", i_gnt, 1'b0);
    chk32("rstmid_maddr", mem_addr, 32'h48);

    // Randomized traffic against a transaction-level model.
    do_reset();
    free_at = cyc + 1;
    last_m = 1'b0; pend = 1'b0; pend_port = 1'b0; pend_wr = 1'b0; done_at = 0;
    pend_data = 32'h0; exp_ir = 32'h0; exp_dr = 32'h0;
    prev_gi = 1'b0; prev_gd = 1'b0;
    for (int n = 0; n < 800; n++) begin
      next_cycle();
      if (prev_gi || !i_req) begin
        i_req  = ($urandom_range(0, 2) == 0);
        i_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end else if ($urandom_range(0, 15) == 0) begin
        i_req = 1'b0;
      end
      if (prev_gd || !d_req) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        d_wdata = $urandom();
        d_be    = 4'($urandom_range(1, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      mid();

      eg_i = 1'b0; eg_d = 1'b0;
      if (pend && cyc == done_at) begin
        if (pend_port == 1'b0) exp_ir = pend_data;
        else if (!pend_wr) exp_dr = pend_data;
      end
      chk1("rnd_idone", i_done, pend && cyc == done_at && pend_port == 1'b0);
      chk1("rnd_ddone", d_done, pend && cyc == done_at && pend_port == 1'b1);
      if (pend && cyc == done_at) pend = 1'b0;

      if (cyc >= free_at && (i_req || d_req)) begin
        win       = (i_req && d_req) ? ~last_m : d_req;
        eg_i      = ~win;
        eg_d      = win;
        last_m    = win;
        pend      = 1'b1;
        pend_port = win;
        pend_wr   = win && d_we;
        pend_data = mem_rd(win ? d_addr : i_addr);
        done_at   = cyc + LAT + 1;
        free_at   = done_at;
      end
      chk1("rnd_ignt", i_gnt, eg_i);
      chk1("rnd_dgnt", d_gnt, eg_d);
      chk1("rnd_men", mem_en, eg_i | eg_d);
      chk32("rnd_irdata", i_rdata, exp_ir);
      chk32("rnd_drdata", d_rdata, exp_dr);
      if (eg_d) begin
        chk32("rnd_maddr", mem_addr, d_addr);
        chk1("rnd_mwe", mem_we, d_we);
        chk32("rnd_mbe", 32'(mem_be), 32'(d_be));
        chk32("rnd_mwdata", mem_wdata, d_wdata);
      end else if (eg_i) begin
        chk32("rnd_maddr", mem_addr, i_addr);
        chk1("rnd_mwe", mem_we, 1'b0);
        chk32("rnd_mbe", 32'(mem_be), 32'hF);
      end else begin
        chk32("rnd_maddr_idle", mem_addr, 32'h0);
        chk32("rnd_mbe_idle", 32'(mem_be), 32'h0);
      end
      prev_gi = eg_i;
      prev_gd = eg_d;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
